// File: rtl/stream_scoreboard_if.sv
// Stream scoreboard bundle: control pulses, expected/actual streams and the
// verdict/statistics outputs. clk and rst_n stay outside as plain ports.
interface stream_scoreboard_if #(
  parameter int W     = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             finish;
  logic             exp_val;
  logic [W-1:0]     exp_dat;
  logic             exp_rdy;
  logic             act_val;
  logic [W-1:0]     act_dat;
  logic             act_rdy;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] mism_cnt;
  logic [W-1:0]     first_exp;
  logic [W-1:0]     first_act;
  logic [CNT_W-1:0] first_idx;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;

  // Stimulus side: drives control and both streams, observes results.
  modport master (
    output start, finish, exp_val, exp_dat, act_val, act_dat,
    input  exp_rdy, act_rdy, match_cnt, mism_cnt, first_exp, first_act,
           first_idx, done, pass, fail, timeout
  );

  // Scoreboard side.
  modport slave (
    input  start, finish, exp_val, exp_dat, act_val, act_dat,
    output exp_rdy, act_rdy, match_cnt, mism_cnt, first_exp, first_act,
           first_idx, done, pass, fail, timeout
  );
endinterface

// File: rtl/stream_scoreboard.sv
// Stream scoreboard: buffers expected words in a FIFO, compares them in order
// against the DUT output stream and produces a registered PASS/FAIL verdict.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | after reset, waiting for start; no handshakes
// S_RUN   | accepting expected words and comparing actual words
// S_DRAIN | no more expected words; comparing until empty or timeout
// S_DONE  | verdict latched one cycle after entry; held until next start
module stream_scoreboard #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16,
  parameter int TMO   = 1024
) (
  input logic                clk,
  input logic                rst_n,
  stream_scoreboard_if.slave sb
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic             w_empty;
  logic             w_full;
  logic [W-1:0]     w_head;

  logic             w_start;
  logic             w_push;
  logic             w_pop;
  logic             w_tmo_hit;
  logic             w_fail_cond;

  logic             r_cmp_v;
  logic             r_cmp_eq;
  logic [W-1:0]     r_cmp_exp;
  logic [W-1:0]     r_cmp_act;
  logic [CNT_W-1:0] r_cmp_idx;
  logic [CNT_W-1:0] r_idx;

  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] r_mism_cnt;
  logic [W-1:0]     r_first_exp;
  logic [W-1:0]     r_first_act;
  logic [CNT_W-1:0] r_first_idx;

  logic [TW-1:0]    r_tmo_cnt;
  logic             r_timeout;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == (AW+1)'(DEPTH));
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign sb.exp_rdy = (r_state == S_RUN) && !w_full;
  assign sb.act_rdy = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !w_empty;

  // A start together with finish while idle is not taken; everywhere else
  // start wins and discards any same-cycle push or pop.
  assign w_start   = sb.start && !((r_state == S_IDLE) && sb.finish);
  assign w_push    = sb.exp_val && sb.exp_rdy && !w_start;
  assign w_pop     = sb.act_val && sb.act_rdy && !w_start;
  assign w_tmo_hit = (r_state == S_DRAIN) && !w_empty && !w_pop &&
                     (r_tmo_cnt == TW'(TMO - 1));

  assign w_fail_cond = (r_mism_cnt != '0) || r_timeout || !w_empty;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (sb.finish) w_state_nxt = S_DRAIN;
        S_DRAIN: if (w_empty || w_tmo_hit) w_state_nxt = S_DONE;
        default: ;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= sb.exp_dat;
  end

  // FIFO pointers; start flushes by zeroing both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Compare stage: capture head vs actual on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_v   <= 1'b0;
      r_cmp_eq  <= 1'b0;
      r_cmp_exp <= '0;
      r_cmp_act <= '0;
      r_cmp_idx <= '0;
      r_idx     <= '0;
    end else if (w_start) begin
      r_cmp_v <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_cmp_v <= w_pop;
      if (w_pop) begin
        r_cmp_eq  <= (w_head == sb.act_dat);
        r_cmp_exp <= w_head;
        r_cmp_act <= sb.act_dat;
        r_cmp_idx <= r_idx;
        if (r_idx != '1) r_idx <= r_idx + CNT_W'(1);
      end
    end
  end

  // Saturating counters and first-mismatch capture from the compare stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_cnt <= '0;
      r_mism_cnt  <= '0;
      r_first_exp <= '0;
      r_first_act <= '0;
      r_first_idx <= '0;
    end else if (w_start) begin
      r_match_cnt <= '0;
      r_mism_cnt  <= '0;
      r_first_exp <= '0;
      r_first_act <= '0;
      r_first_idx <= '0;
    end else if (r_cmp_v) begin
      if (r_cmp_eq) begin
        if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + CNT_W'(1);
      end else begin
        if (r_mism_cnt != '1) r_mism_cnt <= r_mism_cnt + CNT_W'(1);
        if (r_mism_cnt == '0) begin
          r_first_exp <= r_cmp_exp;
          r_first_act <= r_cmp_act;
          r_first_idx <= r_cmp_idx;
        end
      end
    end
  end

  // Drain idle timer: counts DRAIN cycles without a compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else if (w_start) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else if (w_pop) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_DRAIN && !w_empty) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
      if (w_tmo_hit) r_timeout <= 1'b1;
    end
  end

  // Verdict, latched on the first cycle spent in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else if (w_start) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else if (r_state == S_DONE && !r_done) begin
      r_done <= 1'b1;
      r_pass <= !w_fail_cond;
      r_fail <= w_fail_cond;
    end
  end

  assign sb.match_cnt = r_match_cnt;
  assign sb.mism_cnt  = r_mism_cnt;
  assign sb.first_exp = r_first_exp;
  assign sb.first_act = r_first_act;
  assign sb.first_idx = r_first_idx;
  assign sb.done      = r_done;
  assign sb.pass      = r_pass;
  assign sb.fail      = r_fail;
  assign sb.timeout   = r_timeout;

endmodule

// File: tb/tb_stream_scoreboard.sv
// Bench for stream_scoreboard: table vectors, directed multi-cycle sequences,
// randomized runs against a transaction-level model, and a CNT_W=4 instance
// for counter saturation.
module tb_stream_scoreboard;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int TMO   = 1024;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  stream_scoreboard_if #(.W(W), .CNT_W(16)) ifa ();
  stream_scoreboard_if #(.W(W), .CNT_W(4))  ifb ();

  stream_scoreboard #(.W(W), .DEPTH(DEPTH), .CNT_W(16), .TMO(TMO)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sb(ifa));

  stream_scoreboard #(.W(W), .DEPTH(DEPTH), .CNT_W(4), .TMO(TMO)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sb(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (transaction level) ----------------
  logic [7:0] m_q[$];
  int m_ph, m_match, m_mism, m_vmatch, m_vmism, m_idx, m_tcnt;
  int m_fidx;
  logic [7:0] m_fexp, m_fact;
  bit m_tflag, m_done, m_fail;
  bit pd, pp;

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic m_clear();
    m_q.delete();
    m_match = 0; m_mism = 0; m_vmatch = 0; m_vmism = 0;
    m_idx = 0; m_tcnt = 0; m_fidx = 0; m_fexp = 0; m_fact = 0;
    m_tflag = 0; m_done = 0; m_fail = 0;
  endtask

  task automatic m_reset();
    m_clear();
    m_ph = P_IDLE;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // One clock of stimulus on DUT A. Called at posedge+1; returns at posedge+1.
  task automatic step(input bit st, input bit fin, input bit ev, input logic [7:0] ed,
                      input bit av, input logic [7:0] ad,
                      output bit pushed, output bit popped);
    bit er_m, ar_m, emp0;
    int ph0;
    logic [7:0] hd;
    ifa.start = st; ifa.finish = fin;
    ifa.exp_val = ev; ifa.exp_dat = ed;
    ifa.act_val = av; ifa.act_dat = ad;
    pushed = 0; popped = 0;
    @(negedge clk);
    er_m = (m_ph == P_RUN) && (m_q.size() < DEPTH);
    ar_m = (m_ph == P_RUN || m_ph == P_DRAIN) && (m_q.size() > 0);
    chk("exp_rdy", ifa.exp_rdy, er_m);
    chk("act_rdy", ifa.act_rdy, ar_m);
    ph0 = m_ph;
    if (st && !(ph0 == P_IDLE && fin)) begin
      m_clear();
      m_ph = P_RUN;
    end else begin
      emp0 = (m_q.size() == 0);
      m_vmatch = m_match;
      m_vmism  = m_mism;
      if (ph0 == P_DONE && !m_done) begin
        m_done = 1;
        m_fail = (m_mism != 0) || m_tflag || !emp0;
      end
      popped = av && ar_m;
      pushed = ev && er_m;
      if (popped) begin
        hd = m_q.pop_front();
        if (hd == ad) m_match = sat16(m_match + 1);
        else begin
          if (m_mism == 0) begin m_fexp = hd; m_fact = ad; m_fidx = m_idx; end
          m_mism = sat16(m_mism + 1);
        end
        m_idx++;
        m_tcnt = 0;
      end
      if (pushed) m_q.push_back(ed);
      case (ph0)
        P_RUN:   if (fin) m_ph = P_DRAIN;
        P_DRAIN: if (emp0) m_ph = P_DONE;
                 else if (!popped) begin
                   m_tcnt++;
                   if (m_tcnt == TMO) begin m_tflag = 1; m_ph = P_DONE; end
                 end
        default: ;
      endcase
    end
    @(posedge clk); #1;
    ifa.start = 0; ifa.finish = 0; ifa.exp_val = 0; ifa.act_val = 0;
    chk("match_cnt", ifa.match_cnt, m_vmatch);
    chk("mism_cnt", ifa.mism_cnt, m_vmism);
    chk("timeout", ifa.timeout, m_tflag);
    chk("done", ifa.done, m_done);
    chk("pass", ifa.pass, m_done && !m_fail);
    chk("fail", ifa.fail, m_done && m_fail);
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 0, 8'h00, pd, pp);
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && ifa.done !== 1'b1; i++) idle();
    chk("wait_done", ifa.done, 1);
  endtask

  task automatic chk_first_model();
    chk("first_exp_model", ifa.first_exp, m_fexp);
    chk("first_act_model", ifa.first_act, m_fact);
    chk("first_idx_model", ifa.first_idx, m_fidx);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_exp_rdy"}, ifa.exp_rdy, 0);
    chk({tag, "_act_rdy"}, ifa.act_rdy, 0);
    chk({tag, "_match"}, ifa.match_cnt, 0);
    chk({tag, "_mism"}, ifa.mism_cnt, 0);
    chk({tag, "_first_exp"}, ifa.first_exp, 0);
    chk({tag, "_first_act"}, ifa.first_act, 0);
    chk({tag, "_first_idx"}, ifa.first_idx, 0);
    chk({tag, "_done"}, ifa.done, 0);
    chk({tag, "_pass"}, ifa.pass, 0);
    chk({tag, "_fail"}, ifa.fail, 0);
    chk({tag, "_timeout"}, ifa.timeout, 0);
  endtask

  // Table vectors: rdy sampled before the edge, counters/verdict after it.
  typedef struct {
    bit st, fin, ev; logic [7:0] ed; bit av; logic [7:0] ad;
    bit x_er, x_ar; int x_match, x_mism; bit x_done, x_fail;
  } vec_t;

  initial begin
    vec_t tbl[12];
    int acc, nxt, cmps, n;
    bit er_now, ar_now;
    logic [7:0] mis_act[5];

    n_checks = 0; n_err = 0;
    rst_n = 1'b0;
    ifa.start = 0; ifa.finish = 0; ifa.exp_val = 0; ifa.exp_dat = 0;
    ifa.act_val = 0; ifa.act_dat = 0;
    ifb.start = 0; ifb.finish = 0; ifb.exp_val = 0; ifb.exp_dat = 0;
    ifb.act_val = 0; ifb.act_dat = 0;
    m_reset();

    tbl[0]  = '{0,0,0,8'h00,0,8'h00, 0,0, 0,0, 0,0};
    tbl[1]  = '{1,0,0,8'h00,0,8'h00, 0,0, 0,0, 0,0};
    tbl[2]  = '{0,0,1,8'h10,0,8'h00, 1,0, 0,0, 0,0};
    tbl[3]  = '{0,0,1,8'h11,1,8'h10, 1,1, 0,0, 0,0};
    tbl[4]  = '{0,0,0,8'h00,1,8'h22, 1,1, 1,0, 0,0};
    tbl[5]  = '{0,0,0,8'h00,1,8'h33, 1,0, 1,1, 0,0};
    tbl[6]  = '{0,1,0,8'h00,0,8'h00, 1,0, 1,1, 0,0};
    tbl[7]  = '{0,0,0,8'h00,0,8'h00, 0,0, 1,1, 0,0};
    tbl[8]  = '{0,0,0,8'h00,0,8'h00, 0,0, 1,1, 1,1};
    tbl[9]  = '{0,0,0,8'h00,1,8'h44, 0,0, 1,1, 1,1};
    tbl[10] = '{1,1,0,8'h00,0,8'h00, 0,0, 0,0, 0,0};
    tbl[11] = '{0,0,1,8'h55,0,8'h00, 1,0, 0,0, 0,0};

    // Reset state.
    @(posedge clk); #1;
    chk_zero_a("rst");
    chk("rst_b_done", ifb.done, 0);
    chk("rst_b_mism", ifb.mism_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      er_now = ifa.exp_rdy; ar_now = ifa.act_rdy;
      chk($sformatf("tbl%0d_exp_rdy", i), er_now, tbl[i].x_er);
      chk($sformatf("tbl%0d_act_rdy", i), ar_now, tbl[i].x_ar);
      step(tbl[i].st, tbl[i].fin, tbl[i].ev, tbl[i].ed, tbl[i].av, tbl[i].ad, pd, pp);
      chk($sformatf("tbl%0d_match", i), ifa.match_cnt, tbl[i].x_match);
      chk($sformatf("tbl%0d_mism", i), ifa.mism_cnt, tbl[i].x_mism);
      chk($sformatf("tbl%0d_done", i), ifa.done, tbl[i].x_done);
      chk($sformatf("tbl%0d_fail", i), ifa.fail, tbl[i].x_fail);
    end

    // Clean run: 10 words in, same 10 back.
    step(1, 0, 0, 0, 0, 0, pd, pp);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'(i), 0, 0, pd, pp);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 8'(i), pd, pp);
    step(0, 1, 0, 0, 0, 0, pd, pp);
    wait_done(20);
    chk("clean_match", ifa.match_cnt, 10);
    chk("clean_mism", ifa.mism_cnt, 0);
    chk("clean_pass", ifa.pass, 1);
    chk("clean_fail", ifa.fail, 0);

    // Single mismatch at index 2.
    mis_act[0] = 8'h10; mis_act[1] = 8'h11; mis_act[2] = 8'hAA;
    mis_act[3] = 8'h13; mis_act[4] = 8'h14;
    step(1, 0, 0, 0, 0, 0, pd, pp);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'h10 + i), 0, 0, pd, pp);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, mis_act[i], pd, pp);
    step(0, 1, 0, 0, 0, 0, pd, pp);
    wait_done(20);
    chk("mis_mism", ifa.mism_cnt, 1);
    chk("mis_match", ifa.match_cnt, 4);
    chk("mis_first_idx", ifa.first_idx, 2);
    chk("mis_first_exp", ifa.first_exp, 8'h12);
    chk("mis_first_act", ifa.first_act, 8'hAA);
    chk("mis_fail", ifa.fail, 1);
    chk("mis_pass", ifa.pass, 0);

    // Full FIFO and backpressure.
    step(1, 0, 0, 0, 0, 0, pd, pp);
    acc = 0; nxt = 0;
    for (int c = 0; c < 20; c++) begin
      acc += int'(ifa.exp_rdy);
      step(0, 0, 1, 8'(8'h40 + nxt), 0, 0, pd, pp);
      if (pd) nxt++;
    end
    chk("bp_accepted", acc, 16);
    chk("bp_exp_rdy_low", ifa.exp_rdy, 0);
    cmps = 0;
    for (int c = 0; c < 80 && cmps < 20; c++) begin
      step(0, 0, nxt < 20, 8'(8'h40 + nxt), m_q.size() > 0,
           (m_q.size() > 0) ? m_q[0] : 8'h00, pd, pp);
      if (pd) nxt++;
      if (pp) cmps++;
    end
    step(0, 1, 0, 0, 0, 0, pd, pp);
    wait_done(20);
    chk("bp_match", ifa.match_cnt, 20);
    chk("bp_pass", ifa.pass, 1);

    // Drain timeout exactly TMO cycles after the last compare.
    step(1, 0, 0, 0, 0, 0, pd, pp);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(8'h30 + i), 0, 0, pd, pp);
    step(0, 0, 0, 0, 1, 8'h30, pd, pp);
    step(0, 1, 0, 0, 1, 8'h31, pd, pp);
    n = 0;
    while (ifa.timeout !== 1'b1 && n < TMO + 50) begin
      idle();
      n++;
    end
    chk("tmo_cycles", n, TMO);
    wait_done(10);
    chk("tmo_flag", ifa.timeout, 1);
    chk("tmo_fail", ifa.fail, 1);
    chk("tmo_match", ifa.match_cnt, 2);

    // Reset mid-run after 5 compares.
    step(1, 0, 0, 0, 0, 0, pd, pp);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'(8'h60 + i), 0, 0, pd, pp);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 8'(8'h60 + i), pd, pp);
    idle();
    chk("pre_rst_match", ifa.match_cnt, 5);
    rst_n = 1'b0;
    #1;
    chk_zero_a("midrst");
    m_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, pd, pp);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h70 + i), 0, 0, pd, pp);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 8'(8'h70 + i), pd, pp);
    step(0, 1, 0, 0, 0, 0, pd, pp);
    wait_done(20);
    chk("restart_match", ifa.match_cnt, 4);
    chk("restart_pass", ifa.pass, 1);
    step(1, 0, 0, 0, 0, 0, pd, pp);
    chk("restart2_match", ifa.match_cnt, 0);
    chk("restart2_done", ifa.done, 0);
    chk("restart2_pass", ifa.pass, 0);

    // Randomized runs against the model.
    for (int it = 0; it < 8; it++) begin
      step(1, 0, 0, 0, 0, 0, pd, pp);
      n = $urandom_range(60, 20);
      for (int c = 0; c < n; c++) begin
        step(0, 0, 1'($urandom), 8'($urandom), 1'($urandom),
             (m_q.size() > 0 && ($urandom % 4) != 0) ? m_q[0] : 8'($urandom), pd, pp);
      end
      step(0, 1, 0, 0, 0, 0, pd, pp);
      for (int c = 0; c < 200 && ifa.done !== 1'b1; c++) begin
        step(0, 0, 0, 0, m_q.size() > 0,
             (m_q.size() > 0 && ($urandom % 8) != 0) ? m_q[0] : 8'($urandom), pd, pp);
      end
      chk("rand_done", ifa.done, 1);
      chk_first_model();
    end

    // Saturation on the CNT_W=4 instance: 20 mismatching compares.
    ifb.start = 1; @(posedge clk); #1; ifb.start = 0;
    for (int k = 0; k <= 20; k++) begin
      ifb.exp_val = (k < 20);
      ifb.exp_dat = 8'(k);
      ifb.act_val = (k > 0);
      ifb.act_dat = 8'(k - 1) ^ 8'hFF;
      @(posedge clk); #1;
    end
    ifb.exp_val = 0; ifb.act_val = 0;
    ifb.finish = 1; @(posedge clk); #1; ifb.finish = 0;
    for (int c = 0; c < 20 && ifb.done !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    chk("sat_done", ifb.done, 1);
    chk("sat_mism", ifb.mism_cnt, 15);
    chk("sat_match", ifb.match_cnt, 0);
    chk("sat_first_idx", ifb.first_idx, 0);
    chk("sat_first_exp", ifb.first_exp, 8'h00);
    chk("sat_first_act", ifb.first_act, 8'hFF);
    chk("sat_fail", ifb.fail, 1);
    chk("sat_pass", ifb.pass, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
